// File: rtl/adpll_lock_sequencer.sv
// rtl/adpll_lock_sequencer.sv - ADPLL lock sequencer: hold/acquire/track/locked with timeout and retry count
// Moves the loop-filter gains from acquisition to tracking as the phase error settles into the lock window.
module adpll_lock_sequencer #(
  parameter int                    ERROR_WIDTH     = 8,
  parameter int                    KP_WIDTH        = 5,
  parameter int                    KI_WIDTH        = 4,
  parameter logic [KP_WIDTH-1:0]   KP_ACQ          = 5'd8,
  parameter logic [KI_WIDTH-1:0]   KI_ACQ          = 4'd2,
  parameter logic [KP_WIDTH-1:0]   KP_TRK          = 5'd4,
  parameter logic [KI_WIDTH-1:0]   KI_TRK          = 4'd1,
  parameter int unsigned           LOCK_THRESH     = 2,
  parameter int unsigned           ACQ_COUNT       = 16,
  parameter int unsigned           LOCK_COUNT      = 64,
  parameter int unsigned           UNLOCK_COUNT    = 4,
  parameter int unsigned           HOLD_CYCLES     = 32,
  parameter int unsigned           TIMEOUT_SAMPLES = 1024
) (
  input  logic                          fpga_clk_i,
  input  logic                          reset_i,
  input  logic                          enable_i,
  input  logic                          sample_i,
  input  logic signed [ERROR_WIDTH-1:0] error_i,
  output logic                          pll_reset_o,
  output logic [KP_WIDTH-1:0]           kp_o,
  output logic [KI_WIDTH-1:0]           ki_o,
  output logic                          locked_o,
  output logic                          lock_lost_o,
  output logic [2:0]                    state_o,
  output logic [7:0]                    retries_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    ACQUIRE = 3'd2,
    TRACK   = 3'd3,
    LOCKED  = 3'd4
  } state_t;

  localparam int unsigned RUN_MAX = (ACQ_COUNT > LOCK_COUNT) ? ACQ_COUNT : LOCK_COUNT;
  localparam int EW1    = ERROR_WIDTH + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int RUN_W  = $clog2(RUN_MAX + 1);
  localparam int UNL_W  = $clog2(UNLOCK_COUNT + 1);
  localparam int SMP_W  = $clog2(TIMEOUT_SAMPLES + 1);

  localparam logic [EW1-1:0]    THRESH    = EW1'(LOCK_THRESH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [RUN_W-1:0]  RUN_ACQ   = RUN_W'(ACQ_COUNT);
  localparam logic [RUN_W-1:0]  RUN_LCK   = RUN_W'(LOCK_COUNT);
  localparam logic [UNL_W-1:0]  UNL_LIM   = UNL_W'(UNLOCK_COUNT);
  localparam logic [SMP_W-1:0]  SMP_LIM   = SMP_W'(TIMEOUT_SAMPLES);

  state_t             state, state_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic [RUN_W-1:0]   run_cnt, run_n, run_inc, run_goal;
  logic [UNL_W-1:0]   unl_cnt, unl_n, unl_inc;
  logic [SMP_W-1:0]   smp_cnt, smp_n, smp_inc;
  logic [7:0]         retries_n;
  logic               lost_n;
  logic               timeout;

  // One extra bit so the most negative error magnitude is representable.
  logic [EW1-1:0] err_ext, err_abs;
  logic           in_window;
  assign err_ext   = {error_i[ERROR_WIDTH-1], error_i};
  assign err_abs   = err_ext[EW1-1] ? (~err_ext + EW1'(1)) : err_ext;
  assign in_window = (err_abs <= THRESH);

  always_comb begin
    state_n   = state;
    hold_n    = hold_cnt;
    run_n     = run_cnt;
    unl_n     = unl_cnt;
    smp_n     = smp_cnt;
    retries_n = retries_o;
    lost_n    = 1'b0;
    run_inc   = (&run_cnt) ? run_cnt : run_cnt + RUN_W'(1);
    unl_inc   = (&unl_cnt) ? unl_cnt : unl_cnt + UNL_W'(1);
    smp_inc   = (&smp_cnt) ? smp_cnt : smp_cnt + SMP_W'(1);
    run_goal  = (state == TRACK) ? RUN_LCK : RUN_ACQ;
    timeout   = (smp_inc >= SMP_LIM);

    if (!enable_i) begin
      state_n = IDLE;
      hold_n  = '0;
      run_n   = '0;
      unl_n   = '0;
      smp_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = HOLD;
          hold_n  = '0;
        end
        HOLD: begin
          if (hold_cnt >= HOLD_LAST) begin
            state_n = ACQUIRE;
            hold_n  = '0;
            run_n   = '0;
            smp_n   = '0;
          end else begin
            hold_n = hold_cnt + HOLD_W'(1);
          end
        end
        ACQUIRE, TRACK: begin
          if (sample_i) begin
            smp_n = smp_inc;
            // A completed run takes priority over a timeout on the same sample.
            if (in_window && (run_inc >= run_goal)) begin
              state_n = (state == ACQUIRE) ? TRACK : LOCKED;
              run_n   = '0;
            end else if (timeout) begin
              state_n   = HOLD;
              hold_n    = '0;
              run_n     = '0;
              smp_n     = '0;
              retries_n = (&retries_o) ? retries_o : retries_o + 8'd1;
            end else if (in_window) begin
              run_n = run_inc;
            end else begin
              run_n   = '0;
              state_n = ACQUIRE;
            end
          end
        end
        LOCKED: begin
          if (sample_i) begin
            if (in_window) begin
              unl_n = '0;
            end else if (unl_inc >= UNL_LIM) begin
              state_n = ACQUIRE;
              unl_n   = '0;
              run_n   = '0;
              lost_n  = 1'b1;
            end else begin
              unl_n = unl_inc;
            end
          end
        end
        default: begin
          state_n = IDLE;
          hold_n  = '0;
          run_n   = '0;
          unl_n   = '0;
          smp_n   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change one clock after their cause.
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      run_cnt     <= '0;
      unl_cnt     <= '0;
      smp_cnt     <= '0;
      pll_reset_o <= 1'b1;
      kp_o        <= KP_ACQ;
      ki_o        <= KI_ACQ;
      locked_o    <= 1'b0;
      lock_lost_o <= 1'b0;
      state_o     <= IDLE;
      retries_o   <= 8'd0;
    end else begin
      state       <= state_n;
      hold_cnt    <= hold_n;
      run_cnt     <= run_n;
      unl_cnt     <= unl_n;
      smp_cnt     <= smp_n;
      pll_reset_o <= (state_n == IDLE) || (state_n == HOLD);
      kp_o        <= ((state_n == TRACK) || (state_n == LOCKED)) ? KP_TRK : KP_ACQ;
      ki_o        <= ((state_n == TRACK) || (state_n == LOCKED)) ? KI_TRK : KI_ACQ;
      locked_o    <= (state_n == LOCKED);
      lock_lost_o <= lost_n;
      state_o     <= state_n;
      retries_o   <= retries_n;
    end
  end

endmodule

// File: tb/tb_adpll_lock_sequencer.sv
// tb/tb_adpll_lock_sequencer.sv - self-checking bench for adpll_lock_sequencer
// Directed scenarios plus randomized traffic compared every cycle against a behavioural model.
module tb_adpll_lock_sequencer;

  localparam int TO = 128;
  localparam logic [22:0] RST_VEC = {1'b1, 5'd8, 4'd2, 1'b0, 1'b0, 3'd0, 8'd0};

  logic              clk = 1'b0;
  logic              reset_i, enable_i, sample_i;
  logic signed [7:0] error_i;
  logic              pll_reset_o, locked_o, lock_lost_o;
  logic [4:0]        kp_o;
  logic [3:0]        ki_o;
  logic [2:0]        state_o;
  logic [7:0]        retries_o;
  logic [22:0]       dut_vec;

  always #5 clk = ~clk;

  adpll_lock_sequencer #(.TIMEOUT_SAMPLES(TO)) dut (
    .fpga_clk_i (clk),
    .reset_i    (reset_i),
    .enable_i   (enable_i),
    .sample_i   (sample_i),
    .error_i    (error_i),
    .pll_reset_o(pll_reset_o),
    .kp_o       (kp_o),
    .ki_o       (ki_o),
    .locked_o   (locked_o),
    .lock_lost_o(lock_lost_o),
    .state_o    (state_o),
    .retries_o  (retries_o)
  );

  assign dut_vec = {pll_reset_o, kp_o, ki_o, locked_o, lock_lost_o, state_o, retries_o};

  int checks = 0;
  int failures = 0;

  // Model: 0 idle, 1 hold, 2 acquire, 3 track, 4 locked.
  int m_state, m_hold, m_run, m_unl, m_smp, m_ret;
  bit m_lost;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [22:0] model_vec();
    logic [4:0] kp;
    logic [3:0] ki;
    logic       pr, lk;
    kp = (m_state >= 3) ? 5'd4 : 5'd8;
    ki = (m_state >= 3) ? 4'd1 : 4'd2;
    pr = (m_state <= 1);
    lk = (m_state == 4);
    return {pr, kp, ki, lk, m_lost, 3'(m_state), 8'(m_ret)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_hold = 0; m_run = 0; m_unl = 0; m_smp = 0; m_ret = 0; m_lost = 0;
  endtask

  task automatic model_edge(input bit en, input bit smp, input int err);
    int mag;
    bit inw;
    mag = (err < 0) ? -err : err;
    inw = (mag <= 2);
    m_lost = 0;
    if (!en) begin
      m_state = 0; m_hold = 0; m_run = 0; m_unl = 0; m_smp = 0;
      return;
    end
    case (m_state)
      0: begin m_state = 1; m_hold = 0; end
      1: begin
        m_hold++;
        if (m_hold == 32) begin m_state = 2; m_hold = 0; m_run = 0; m_smp = 0; end
      end
      2, 3: if (smp) begin
        m_smp++;
        if (inw && (m_run + 1 == ((m_state == 2) ? 16 : 64))) begin
          m_state++; m_run = 0;
        end else if (m_smp == TO) begin
          m_state = 1; m_hold = 0; m_run = 0; m_smp = 0;
          if (m_ret < 255) m_ret++;
        end else if (inw) begin
          m_run++;
        end else begin
          m_run = 0; m_state = 2;
        end
      end
      4: if (smp) begin
        if (inw) m_unl = 0;
        else begin
          m_unl++;
          if (m_unl == 4) begin m_state = 2; m_unl = 0; m_run = 0; m_lost = 1; end
        end
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic step(input bit en, input bit smp, input logic signed [7:0] err);
    int e;
    e = err;
    enable_i = en; sample_i = smp; error_i = err;
    @(posedge clk);
    model_edge(en, smp, e);
    #1;
    check("outputs", 32'(dut_vec), 32'(model_vec()));
  endtask

  int n_smp, acq_cyc, trk_n, lck_n;
  int seq28 [8] = '{3, 3, 3, 0, 3, 3, 3, -128};

  initial begin
    reset_i = 1'b1; enable_i = 1'b0; sample_i = 1'b0; error_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_vec", 32'(dut_vec), 32'(RST_VEC));
    reset_i = 1'b0;

    // Slow sampling: hold release, acquire and lock points.
    n_smp = 0; acq_cyc = 0; trk_n = 0; lck_n = 0;
    for (int c = 1; c <= 1500 && lck_n == 0; c++) begin
      bit s;
      s = (c % 8 == 0);
      if (s && (m_state == 2 || m_state == 3)) n_smp++;
      step(1'b1, s, 8'sd0);
      if (acq_cyc == 0 && !pll_reset_o) acq_cyc = c;
      if (trk_n == 0 && state_o == 3'd3) trk_n = n_smp;
      if (locked_o) lck_n = n_smp;
    end
    check("hold_release_cycle", 32'(acq_cyc), 32'd33);
    check("track_after_samples", 32'(trk_n), 32'd16);
    check("lock_after_samples", 32'(lck_n), 32'd80);

    // Unlock needs four consecutive out-of-window samples.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 8'(seq28[i]));
      check("lock_lost_pulse", 32'(lock_lost_o), 32'(i == 7));
    end
    check("unlock_state", 32'(state_o), 32'd2);
    check("unlock_kp", 32'(kp_o), 32'd8);

    // Run clears on error 3 and on the most negative error.
    step(1'b1, 1'b1, 8'sd0);
    step(1'b1, 1'b1, 8'sd0);
    step(1'b1, 1'b1, 8'sd3);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 8'sd0);
    check("run_clear_on_3", 32'(state_o), 32'd2);
    step(1'b1, 1'b1, -8'sd128);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 8'sd0);
    check("run_clear_on_min", 32'(state_o), 32'd2);
    step(1'b1, 1'b1, 8'sd0);
    check("track_after_16", 32'(state_o), 32'd3);

    step(1'b0, 1'b0, 8'sd0);
    check("enable_drop_track", 32'(state_o), 32'd0);

    // Constant large error: periodic timeouts, retries saturate.
    for (int i = 0; i < 160; i++) step(1'b1, 1'b1, 8'sd50);
    check("before_timeout_state", 32'(state_o), 32'd2);
    step(1'b1, 1'b1, 8'sd50);
    check("timeout_state", 32'(state_o), 32'd1);
    check("timeout_retries", 32'(retries_o), 32'd1);
    for (int i = 0; i < 299 * 160; i++) step(1'b1, 1'b1, 8'sd50);
    check("retries_saturated", 32'(retries_o), 32'd255);
    step(1'b0, 1'b0, 8'sd0);
    check("retries_kept_on_disable", 32'(retries_o), 32'd255);

    // Fast lock, then drop enable while locked.
    for (int i = 0; i < 112; i++) step(1'b1, 1'b1, 8'sd1);
    check("not_yet_locked", 32'(locked_o), 32'd0);
    step(1'b1, 1'b1, -8'sd2);
    check("locked_at_113", 32'(locked_o), 32'd1);
    step(1'b0, 1'b0, 8'sd0);
    check("disable_in_locked", 32'({state_o, pll_reset_o, locked_o}), 32'({3'd0, 1'b1, 1'b0}));

    // Asynchronous reset in the middle of tracking.
    for (int i = 0; i < 54; i++) step(1'b1, 1'b1, 8'sd0);
    check("mid_track_state", 32'(state_o), 32'd3);
    #3 reset_i = 1'b1;
    #1;
    check("async_reset_vec", 32'(dut_vec), 32'(RST_VEC));
    model_reset();
    @(posedge clk);
    #1 reset_i = 1'b0;

    // Randomized traffic in segments of varying error quality.
    for (int seg = 0; seg < 20; seg++) begin
      int p_out;
      p_out = $urandom_range(0, 20);
      for (int i = 0; i < 200; i++) begin
        bit en, s;
        logic signed [7:0] e;
        en = ($urandom_range(0, 299) != 0);
        s  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 99) < p_out) e = 8'($urandom_range(0, 255));
        else e = 8'($signed($urandom_range(0, 4)) - 2);
        step(en, s, e);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
